// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the memory-mapped UART transmitter.
// Holds the transmit FSM state enum, the register offsets within the 8-byte
// window, and the STATUS bit positions.
// Optional feature macro: UART_TX_PARITY_EN adds the PARITY state and the
// even-parity helper.
package uart_pkg;

  // Serial framing widths
  localparam int unsigned DATA_W    = 8;
  localparam int unsigned BIT_CNT_W = 3;
  localparam int unsigned DIV_W     = 16;

  // Register offsets; bits [1:0] of the address are ignored
  localparam logic [2:0] TXDATA_OFS = 3'd0;
  localparam logic [2:0] STATUS_OFS = 3'd4;

  // STATUS bit layout
  localparam int unsigned STAT_BUSY      = 0;
  localparam int unsigned STAT_EMPTY     = 1;
  localparam int unsigned STAT_OVF       = 2;
  localparam int unsigned STAT_COUNT_LSB = 3;
  localparam int unsigned STAT_COUNT_W   = 3;

  // Transmit FSM states
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } txState_t;

`ifdef UART_TX_PARITY_EN
  // Even parity: XOR of all data bits
  function automatic logic evenParity(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction
`endif

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock first-word-fall-through FIFO.
// Ports:
//   clk    - clock, rising edge
//   rst_n  - asynchronous active-low reset; empties the FIFO
//   push   - write din (ignored when full)
//   pop    - advance head (ignored when empty)
//   din    - write data
//   dout   - head entry, valid while empty is low
//   full   - count == DEPTH
//   empty  - count == 0
//   count  - occupancy, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wrPtr;
  logic [AW-1:0]    rdPtr;
  logic             doPush;
  logic             doPop;

  assign full   = (count == FULL_CNT);
  assign empty  = (count == '0);
  assign doPush = push && !full;
  assign doPop  = pop && !empty;
  assign dout   = mem[rdPtr];

  // Storage; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (doPush) begin
      mem[wrPtr] <= din;
    end
  end

  // Pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) begin
        wrPtr <= wrPtr + AW'(1);
      end
      if (doPop) begin
        rdPtr <= rdPtr + AW'(1);
      end
      case ({doPush, doPop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped UART transmitter with a small transmit FIFO.
// Register window at BASE_ADDR (8 bytes, addr[1:0] ignored):
//   +0 TXDATA  write: queue wdata[7:0]; read: 0
//   +4 STATUS  read: {count[2:0], ovf, empty, busy}; write wdata[2]=1 clears ovf
// Ports:
//   clk    - clock, rising edge
//   reset  - asynchronous active-low reset; aborts any frame, empties the FIFO
//   we     - store strobe from the core's memory stage
//   addr   - byte address
//   wdata  - store data
//   rdata  - combinational read data for the addressed register
//   hit    - combinational window decode
//   tx     - serial line, idle high, 8N1 frames of CLK_DIV clocks per bit
// Optional feature macro: UART_TX_PARITY_EN adds an even-parity bit (8E1).
module mmio_uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 16,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_1000,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        hit,
  output logic        tx
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(CLK_DIV - 1);

  // Address decode
  logic selTxData;
  logic selStatus;
  logic wrTxData;
  logic wrStatus;

  assign hit       = (addr[31:3] == BASE_ADDR[31:3]);
  assign selTxData = ({addr[2], 2'b00} == TXDATA_OFS);
  assign selStatus = ({addr[2], 2'b00} == STATUS_OFS);
  assign wrTxData  = we && hit && selTxData;
  assign wrStatus  = we && hit && selStatus;

  // Address byte lanes and upper store data carry no meaning here
  logic unusedBits;
  assign unusedBits = ^{addr[1:0], wdata[31:8]};

  // Transmit FIFO
  logic [DATA_W-1:0] fifoDout;
  logic              fifoFull;
  logic              fifoEmpty;
  logic [CNT_W-1:0]  fifoCount;
  logic              fifoPop;

  sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) uFifo (
    .clk   (clk),
    .rst_n (reset),
    .push  (wrTxData),
    .pop   (fifoPop),
    .din   (wdata[DATA_W-1:0]),
    .dout  (fifoDout),
    .full  (fifoFull),
    .empty (fifoEmpty),
    .count (fifoCount)
  );

  // Sticky overflow: a TXDATA store that finds the FIFO full is dropped.
  // Fullness is the pre-edge value, so a same-cycle pop does not make room.
  logic ovf;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf <= 1'b0;
    end else if (wrTxData && fifoFull) begin
      ovf <= 1'b1;
    end else if (wrStatus && wdata[STAT_OVF]) begin
      ovf <= 1'b0;
    end
  end

  // Transmit FSM state and datapath
  txState_t          state;
  txState_t          stateNext;
  logic [DIV_W-1:0]  divCnt;
  logic [DIV_W-1:0]  divNext;
  logic [BIT_CNT_W-1:0] bitCnt;
  logic [BIT_CNT_W-1:0] bitNext;
  logic [DATA_W-1:0] shReg;
  logic [DATA_W-1:0] shNext;
  logic              txReg;
  logic              txNext;
  logic              bitDone;
  logic              busy;
`ifdef UART_TX_PARITY_EN
  logic              parBit;
  logic              parNext;
`endif

  assign bitDone = (divCnt == '0);
  assign busy    = (state != IDLE);
  assign tx      = txReg;

  // State register; reset forces the line high at once
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      divCnt <= '0;
      bitCnt <= '0;
      shReg  <= '0;
      txReg  <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parBit <= 1'b0;
`endif
    end else begin
      state  <= stateNext;
      divCnt <= divNext;
      bitCnt <= bitNext;
      shReg  <= shNext;
      txReg  <= txNext;
`ifdef UART_TX_PARITY_EN
      parBit <= parNext;
`endif
    end
  end

  // Next-state logic; tx is registered, so each value lands with its state
  always_comb begin
    stateNext = state;
    divNext   = divCnt;
    bitNext   = bitCnt;
    shNext    = shReg;
    txNext    = txReg;
    fifoPop   = 1'b0;
`ifdef UART_TX_PARITY_EN
    parNext   = parBit;
`endif

    // Bit timer runs down in every non-idle state
    if (state != IDLE && !bitDone) begin
      divNext = divCnt - DIV_W'(1);
    end

    case (state)
      IDLE: begin
        txNext = 1'b1;
        if (!fifoEmpty) begin
          fifoPop   = 1'b1;
          shNext    = fifoDout;
          bitNext   = '0;
          divNext   = DIV_RELOAD;
          txNext    = 1'b0;
          stateNext = START;
`ifdef UART_TX_PARITY_EN
          parNext   = evenParity(fifoDout);
`endif
        end
      end

      START: begin
        if (bitDone) begin
          divNext   = DIV_RELOAD;
          bitNext   = '0;
          txNext    = shReg[0];
          stateNext = DATA;
        end
      end

      DATA: begin
        if (bitDone) begin
          divNext = DIV_RELOAD;
          bitNext = bitCnt + BIT_CNT_W'(1);
          if (bitCnt == BIT_CNT_W'(DATA_W - 1)) begin
`ifdef UART_TX_PARITY_EN
            txNext    = parBit;
            stateNext = PARITY;
`else
            txNext    = 1'b1;
            stateNext = STOP;
`endif
          end else begin
            shNext = {1'b0, shReg[DATA_W-1:1]};
            txNext = shReg[1];
          end
        end
      end

`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bitDone) begin
          divNext   = DIV_RELOAD;
          txNext    = 1'b1;
          stateNext = STOP;
        end
      end
`endif

      STOP: begin
        if (bitDone) begin
          if (!fifoEmpty) begin
            // Chain straight into the next frame without an idle bit
            fifoPop   = 1'b1;
            shNext    = fifoDout;
            bitNext   = '0;
            divNext   = DIV_RELOAD;
            txNext    = 1'b0;
            stateNext = START;
`ifdef UART_TX_PARITY_EN
            parNext   = evenParity(fifoDout);
`endif
          end else begin
            divNext   = '0;
            txNext    = 1'b1;
            stateNext = IDLE;
          end
        end
      end

      default: begin
        divNext   = '0;
        txNext    = 1'b1;
        stateNext = IDLE;
      end
    endcase
  end

  // Register read mux
  logic [31:0] statusWord;

  always_comb begin
    statusWord = '0;
    statusWord[STAT_BUSY]  = busy;
    statusWord[STAT_EMPTY] = fifoEmpty;
    statusWord[STAT_OVF]   = ovf;
    statusWord[STAT_COUNT_LSB +: STAT_COUNT_W] = STAT_COUNT_W'(fifoCount);
    rdata = '0;
    if (hit && selStatus) begin
      rdata = statusWord;
    end
  end

endmodule
